// File: rtl/range_slice_queue_pkg.sv
// Shared types and helpers for the range-slice queue: slice FSM states and
// the request range check.
package range_slice_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } slice_state_e;

  // A slice is legal when both indices are non-negative, ordered, and the
  // last index addresses an occupied entry.
  function automatic logic range_ok(input logic signed [31:0] start_idx,
                                    input logic signed [31:0] end_idx,
                                    input logic [31:0]        size);
    return (start_idx >= 0) && (end_idx >= 0) && (start_idx <= end_idx) &&
           ($unsigned(end_idx) < size);
  endfunction

endpackage

// File: rtl/range_slice_queue_store.sv
// Circular storage for the range-slice queue: memory array, head/tail/count
// and push/pop bookkeeping. Offers two head-relative combinational read ports.
module range_queue_store
  import range_slice_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int DROP_ZERO = 0,
  localparam int AW       = $clog2(DEPTH),
  localparam int CNT_W    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_ready,
  input  logic             pop_en,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  input  logic [AW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head_reg;
  logic [AW-1:0]    tail_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_accept;
  logic             store_en;
  logic             pop_do;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    peek_addr;

  // Full-ness comes from the registered count only, so a same-cycle pop
  // never makes room for a push.
  assign push_ready  = (count_reg < CNT_W'(DEPTH));
  assign push_accept = push_valid && push_ready;
  assign store_en    = push_accept && !((DROP_ZERO != 0) && (push_data == '0));
  assign pop_do      = pop_en && (count_reg != '0);

  // Index sums wrap naturally in AW bits because DEPTH is a power of two.
  assign rd_addr   = head_reg + rd_idx;
  assign peek_addr = head_reg + peek_idx;
  assign rd_data   = mem[rd_addr];
  assign peek_data = mem[peek_addr];
  assign count     = count_reg;

  // Storage write at the tail; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem[tail_reg] <= push_data;
    end
  end

  // Pointer and occupancy tracking; push and pop together leave count as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (store_en) tail_reg <= tail_reg + 1'b1;
      if (pop_do)   head_reg <= head_reg + 1'b1;
      if (store_en && !pop_do)      count_reg <= count_reg + 1'b1;
      else if (!store_en && pop_do) count_reg <= count_reg - 1'b1;
    end
  end

endmodule

// File: rtl/range_slice_queue.sv
// Range-slice queue top: circular queue with push/pop plus a windowed read
// port that streams head-relative elements [start..end] on valid/ready.
module range_slice_queue
  import range_slice_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 16,
  parameter int DROP_ZERO = 0,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push_valid,
  input  logic [WIDTH-1:0]    push_data,
  output logic                push_ready,
  input  logic                pop_en,
  input  logic                slice_req_valid,
  output logic                slice_req_ready,
  input  logic signed [31:0]  slice_start,
  input  logic signed [31:0]  slice_end,
  output logic                slice_out_valid,
  input  logic                slice_out_ready,
  output logic [WIDTH-1:0]    slice_out_data,
  output logic                slice_out_last,
  output logic                slice_err,
  output logic [WIDTH-1:0]    slice_first,
  output logic [CNT_W-1:0]    q_size
);

  localparam int AW = CNT_W - 1;

  slice_state_e     state_reg, state_next;
  logic [AW-1:0]    rd_idx_reg, rd_idx_next;
  logic [AW-1:0]    rd_end_reg, rd_end_next;
  logic             slice_err_reg, slice_err_next;
  logic [WIDTH-1:0] slice_first_reg, slice_first_next;
  logic [WIDTH-1:0] rd_data;
  logic [WIDTH-1:0] peek_data;
  logic             store_pop;

  // Pops are frozen while streaming so head-relative indices stay put.
  assign store_pop = pop_en && (state_reg == IDLE);

  range_queue_store #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .DROP_ZERO (DROP_ZERO)
  ) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_en     (store_pop),
    .rd_idx     (rd_idx_reg),
    .rd_data    (rd_data),
    .peek_idx   (slice_start[AW-1:0]),
    .peek_data  (peek_data),
    .count      (q_size)
  );

  // Slice FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Slice datapath registers: stream cursor, error pulse, first element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_idx_reg      <= '0;
      rd_end_reg      <= '0;
      slice_err_reg   <= 1'b0;
      slice_first_reg <= '0;
    end else begin
      rd_idx_reg      <= rd_idx_next;
      rd_end_reg      <= rd_end_next;
      slice_err_reg   <= slice_err_next;
      slice_first_reg <= slice_first_next;
    end
  end

  // Next-state logic and handshake outputs for the slice FSM.
  always_comb begin
    state_next       = state_reg;
    rd_idx_next      = rd_idx_reg;
    rd_end_next      = rd_end_reg;
    slice_err_next   = 1'b0;
    slice_first_next = slice_first_reg;
    slice_req_ready  = 1'b0;
    slice_out_valid  = 1'b0;
    slice_out_last   = 1'b0;
    slice_out_data   = '0;
    case (state_reg)
      IDLE: begin
        slice_req_ready = 1'b1;
        if (slice_req_valid) begin
          if (range_ok(slice_start, slice_end, 32'(q_size))) begin
            state_next       = STREAM;
            rd_idx_next      = slice_start[AW-1:0];
            rd_end_next      = slice_end[AW-1:0];
            slice_first_next = peek_data;
          end else begin
            slice_err_next   = 1'b1;
            slice_first_next = '0;
          end
        end
      end
      STREAM: begin
        slice_out_valid = 1'b1;
        slice_out_last  = (rd_idx_reg == rd_end_reg);
        slice_out_data  = rd_data;
        if (slice_out_ready) begin
          if (rd_idx_reg == rd_end_reg) state_next = IDLE;
          else                          rd_idx_next = rd_idx_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign slice_err   = slice_err_reg;
  assign slice_first = slice_first_reg;

endmodule

// File: tb/tb_range_slice_queue.sv
// Self-checking bench for range_slice_queue: a 16-deep instance checked
// against a queue-based reference model, and a 4-deep DROP_ZERO instance
// exercised with directed boundary cases.
module tb_range_slice_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Main instance (DEPTH=16, DROP_ZERO=0)
  logic               rst_n, push_valid, push_ready, pop_en;
  logic [31:0]        push_data;
  logic               slice_req_valid, slice_req_ready;
  logic signed [31:0] slice_start, slice_end;
  logic               slice_out_valid, slice_out_ready, slice_out_last, slice_err;
  logic [31:0]        slice_out_data, slice_first;
  logic [4:0]         q_size;

  // Small instance (DEPTH=4, DROP_ZERO=1)
  logic               s_rst_n, s_push_valid, s_push_ready, s_pop_en;
  logic [31:0]        s_push_data;
  logic               s_req_valid, s_req_ready;
  logic signed [31:0] s_start, s_end;
  logic               s_out_valid, s_out_ready, s_out_last, s_err;
  logic [31:0]        s_out_data, s_first;
  logic [2:0]         s_q_size;

  range_slice_queue #(.WIDTH(32), .DEPTH(16), .DROP_ZERO(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .pop_en(pop_en), .slice_req_valid(slice_req_valid),
    .slice_req_ready(slice_req_ready), .slice_start(slice_start), .slice_end(slice_end),
    .slice_out_valid(slice_out_valid), .slice_out_ready(slice_out_ready),
    .slice_out_data(slice_out_data), .slice_out_last(slice_out_last),
    .slice_err(slice_err), .slice_first(slice_first), .q_size(q_size)
  );

  range_slice_queue #(.WIDTH(32), .DEPTH(4), .DROP_ZERO(1)) u_small (
    .clk(clk), .rst_n(s_rst_n), .push_valid(s_push_valid), .push_data(s_push_data),
    .push_ready(s_push_ready), .pop_en(s_pop_en), .slice_req_valid(s_req_valid),
    .slice_req_ready(s_req_ready), .slice_start(s_start), .slice_end(s_end),
    .slice_out_valid(s_out_valid), .slice_out_ready(s_out_ready),
    .slice_out_data(s_out_data), .slice_out_last(s_out_last),
    .slice_err(s_err), .slice_first(s_first), .q_size(s_q_size)
  );

  // Reference model of the main instance: the queue contents, head first.
  logic [31:0] model_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one clock edge's worth of push/pop to the model.
  task automatic model_step(input logic pv, input logic [31:0] pd,
                            input logic pe, input bit idle);
    int sz;
    sz = model_q.size();
    if (pe && idle && sz > 0) void'(model_q.pop_front());
    if (pv && sz < 16) model_q.push_back(pd);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_rst_n = 1'b0;
    push_valid = 0; push_data = 0; pop_en = 0; slice_req_valid = 0;
    slice_start = 0; slice_end = 0; slice_out_ready = 1;
    s_push_valid = 0; s_push_data = 0; s_pop_en = 0; s_req_valid = 0;
    s_start = 0; s_end = 0; s_out_ready = 1;
    tick(); tick();
    checks++;
    if (push_ready !== 1'b1 || slice_req_ready !== 1'b1 || slice_out_valid !== 1'b0 ||
        slice_out_last !== 1'b0 || slice_out_data !== 32'd0 || slice_err !== 1'b0 ||
        slice_first !== 32'd0 || q_size !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got pr=%b rr=%b v=%b l=%b d=%0d e=%b f=%0d q=%0d, want 1 1 0 0 0 0 0 0",
               push_ready, slice_req_ready, slice_out_valid, slice_out_last,
               slice_out_data, slice_err, slice_first, q_size);
    end
    rst_n = 1'b1; s_rst_n = 1'b1;
    model_q.delete();
    tick();
    $display("reset: q_size=%0d push_ready=%b", q_size, push_ready);
  endtask

  task automatic test_push_basic();
    for (int i = 1; i <= 5; i++) begin
      push_valid = 1; push_data = 32'(i * 10);
      tick();
      model_step(1'b1, 32'(i * 10), 1'b0, 1'b1);
      $display("push %0d: q_size=%0d", i * 10, q_size);
    end
    push_valid = 0;
    checks++;
    if (q_size !== 5'(model_q.size()) || push_ready !== 1'b1 || slice_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL push_basic: got q=%0d pr=%b v=%b, want q=%0d pr=1 v=0",
               q_size, push_ready, slice_out_valid, model_q.size());
    end
  endtask

  // Stream a valid slice, optionally stalling one beat or randomising ready,
  // pushes and pop attempts while the stream is in flight.
  task automatic stream_slice(input int s, input int e, input int stall_at,
                              input int stall_n, input bit rnd, input bit pop_try);
    int k, cyc, stalls;
    logic [31:0] exp_first, pd;
    logic pv, pe;
    bit rdy;
    exp_first = model_q[s];
    slice_req_valid = 1; slice_start = s; slice_end = e;
    tick();
    slice_req_valid = 0;
    checks++;
    if (slice_first !== exp_first) begin
      errors++;
      $display("FAIL slice_first[%0d..%0d]: got %0d want %0d", s, e, slice_first, exp_first);
    end
    k = s; cyc = 0; stalls = 0;
    while (k <= e && cyc < 300) begin
      if (rnd) rdy = ($urandom_range(0, 2) != 0);
      else begin
        rdy = !(k == stall_at && stalls < stall_n);
        if (!rdy) stalls++;
      end
      pv = rnd && ($urandom_range(0, 3) == 0);
      pd = $urandom;
      pe = pop_try || (rnd && ($urandom_range(0, 3) == 0));
      checks++;
      if (slice_out_valid !== 1'b1 || slice_out_data !== model_q[k] ||
          slice_out_last !== (k == e)) begin
        errors++;
        $display("FAIL beat[%0d]: got v=%b d=%0d l=%b, want v=1 d=%0d l=%b",
                 k, slice_out_valid, slice_out_data, slice_out_last, model_q[k], (k == e));
      end
      slice_out_ready = rdy; push_valid = pv; push_data = pd; pop_en = pe;
      tick();
      model_step(pv, pd, pe, 1'b0);
      if (rdy) k++;
      cyc++;
    end
    push_valid = 0; pop_en = 0; slice_out_ready = 1;
    if (cyc >= 300) begin
      checks++; errors++;
      $display("FAIL stream_timeout: beat %0d of %0d..%0d never finished", k, s, e);
    end
    checks++;
    if (slice_out_valid !== 1'b0 || slice_req_ready !== 1'b1 ||
        q_size !== 5'(model_q.size())) begin
      errors++;
      $display("FAIL stream_end[%0d..%0d]: got v=%b rr=%b q=%0d, want v=0 rr=1 q=%0d",
               s, e, slice_out_valid, slice_req_ready, q_size, model_q.size());
    end
    $display("slice %0d..%0d: %0d cycles, first=%0d q_size=%0d", s, e, cyc, slice_first, q_size);
  endtask

  task automatic test_invalid(input int s, input int e);
    slice_req_valid = 1; slice_start = s; slice_end = e;
    tick();
    slice_req_valid = 0;
    checks++;
    if (slice_err !== 1'b1 || slice_first !== 32'd0 || slice_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL invalid_pulse[%0d..%0d]: got err=%b first=%0d v=%b, want 1 0 0",
               s, e, slice_err, slice_first, slice_out_valid);
    end
    tick();
    checks++;
    if (slice_err !== 1'b0 || slice_out_valid !== 1'b0 || slice_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL invalid_after[%0d..%0d]: got err=%b v=%b rr=%b, want 0 0 1",
               s, e, slice_err, slice_out_valid, slice_req_ready);
    end
    $display("invalid slice %0d..%0d rejected", s, e);
  endtask

  task automatic test_pop_idle();
    pop_en = 1;
    tick();
    model_step(1'b0, 32'd0, 1'b1, 1'b1);
    pop_en = 0;
    checks++;
    if (q_size !== 5'(model_q.size())) begin
      errors++;
      $display("FAIL pop_idle: got q=%0d want %0d", q_size, model_q.size());
    end
    $display("pop: q_size=%0d", q_size);
  endtask

  task automatic test_random();
    for (int it = 0; it < 150; it++) begin
      int op, s, e, sz;
      logic pv, pe;
      logic [31:0] pd;
      op = $urandom_range(0, 4);
      sz = model_q.size();
      if (op == 4) begin
        s = $urandom_range(0, 19) - 2;
        e = $urandom_range(0, 19) - 2;
        if (s >= 0 && e >= 0 && s <= e && e < sz) stream_slice(s, e, -1, 0, 1'b1, 1'b0);
        else test_invalid(s, e);
      end else begin
        pv = (op == 0 || op == 2 || op == 3);
        pe = (op == 1 || op == 2);
        pd = $urandom;
        push_valid = pv; push_data = pd; pop_en = pe;
        tick();
        model_step(pv, pd, pe, 1'b1);
        push_valid = 0; pop_en = 0;
        checks++;
        if (q_size !== 5'(model_q.size()) || push_ready !== (model_q.size() < 16)) begin
          errors++;
          $display("FAIL random_op[%0d]: got q=%0d pr=%b, want q=%0d pr=%b",
                   it, q_size, push_ready, model_q.size(), (model_q.size() < 16));
        end
        $display("op %0d push=%b pop=%b: q_size=%0d", it, pv, pe, q_size);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    while (model_q.size() < 4) begin
      push_valid = 1; push_data = $urandom;
      tick();
      model_step(1'b1, push_data, 1'b0, 1'b1);
    end
    push_valid = 0;
    slice_req_valid = 1; slice_start = 0; slice_end = model_q.size() - 1;
    tick();
    slice_req_valid = 0;
    tick();
    checks++;
    if (slice_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got v=%b want 1", slice_out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (slice_out_valid !== 1'b0 || q_size !== 5'd0 || slice_out_data !== 32'd0) begin
      errors++;
      $display("FAIL midreset_async: got v=%b q=%0d d=%0d, want 0 0 0",
               slice_out_valid, q_size, slice_out_data);
    end
    tick();
    rst_n = 1'b1;
    model_q.delete();
    tick();
    $display("mid-stream reset: v=%b q_size=%0d", slice_out_valid, q_size);
  endtask

  task automatic test_small_depth();
    int exp_d[4];
    for (int i = 1; i <= 4; i++) begin
      s_push_valid = 1; s_push_data = 32'(i);
      tick();
    end
    checks++;
    if (s_push_ready !== 1'b0 || s_q_size !== 3'd4) begin
      errors++;
      $display("FAIL small_full: got pr=%b q=%0d, want 0 4", s_push_ready, s_q_size);
    end
    s_push_data = 32'd5;
    tick();
    checks++;
    if (s_q_size !== 3'd4 || s_push_ready !== 1'b0) begin
      errors++;
      $display("FAIL small_drop_full: got q=%0d pr=%b, want 4 0", s_q_size, s_push_ready);
    end
    s_push_data = 32'd6; s_pop_en = 1;
    tick();
    s_push_valid = 0; s_pop_en = 0;
    checks++;
    if (s_q_size !== 3'd3 || s_push_ready !== 1'b1) begin
      errors++;
      $display("FAIL small_pushpop_full: got q=%0d pr=%b, want 3 1", s_q_size, s_push_ready);
    end
    s_req_valid = 1; s_start = 0; s_end = 0;
    tick();
    s_req_valid = 0;
    checks++;
    if (s_first !== 32'd2 || s_out_valid !== 1'b1 || s_out_data !== 32'd2 || s_out_last !== 1'b1) begin
      errors++;
      $display("FAIL small_head: got first=%0d v=%b d=%0d l=%b, want 2 1 2 1",
               s_first, s_out_valid, s_out_data, s_out_last);
    end
    tick();
    s_push_valid = 1; s_push_data = 32'd0;
    tick();
    checks++;
    if (s_q_size !== 3'd3) begin
      errors++;
      $display("FAIL small_drop_zero: got q=%0d want 3", s_q_size);
    end
    s_push_data = 32'd7;
    tick();
    s_push_valid = 0;
    exp_d = '{2, 3, 4, 7};
    s_req_valid = 1; s_start = 0; s_end = 3;
    tick();
    s_req_valid = 0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (s_out_valid !== 1'b1 || s_out_data !== 32'(exp_d[k]) || s_out_last !== (k == 3)) begin
        errors++;
        $display("FAIL small_wrap_beat[%0d]: got v=%b d=%0d l=%b, want 1 %0d %b",
                 k, s_out_valid, s_out_data, s_out_last, exp_d[k], (k == 3));
      end
      tick();
    end
    checks++;
    if (s_out_valid !== 1'b0 || s_q_size !== 3'd4) begin
      errors++;
      $display("FAIL small_wrap_end: got v=%b q=%0d, want 0 4", s_out_valid, s_q_size);
    end
    $display("small depth: q_size=%0d first=%0d", s_q_size, s_first);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_push_basic();
    stream_slice(1, 3, -1, 0, 1'b0, 1'b0);
    stream_slice(1, 3, 2, 3, 1'b0, 1'b0);
    test_invalid(3, 1);
    test_invalid(0, 5);
    test_invalid(-1, 2);
    stream_slice(0, 4, -1, 0, 1'b0, 1'b1);
    test_pop_idle();
    test_small_depth();
    test_random();
    test_reset_mid_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/range_slice_queue.md
Name: range_slice_queue

Overview:
- Parametrised circular queue with push/pop and a range-slice read port.
- A slice request gives start/end indices relative to the current head. The block checks the range, then streams elements [start..end] one per cycle on a valid/ready output.
- It sits between a producer of data words and a consumer that needs windowed reads without popping. Pushes are ready-gated; pops and slices do not conflict.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, queue capacity in entries; power of two, >= 2.
- DROP_ZERO, 0, when 1 an accepted push of all-zero data is discarded (no store, no count change).
- CNT_W (localparam), $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push_valid  input  1  push request.
- push_data  input  WIDTH  word to append at the tail.
- push_ready  output  1  high when count < DEPTH.
- pop_en  input  1  remove the head entry.
- slice_req_valid  input  1  slice request.
- slice_req_ready  output  1  high in IDLE.
- slice_start  input  32 signed  first index, head-relative.
- slice_end  input  32 signed  last index, head-relative, inclusive.
- slice_out_valid  output  1  slice beat valid.
- slice_out_ready  input  1  consumer accepts beat.
- slice_out_data  output  WIDTH  beat data; 0 when slice_out_valid is low.
- slice_out_last  output  1  final beat of the slice.
- slice_err  output  1  one-cycle pulse on a rejected request.
- slice_first  output  WIDTH  first element of the most recent accepted slice; 0 after a rejected one.
- q_size  output  CNT_W  current occupancy.

Behaviour:
- Reset (asynchronous, active-low): head=tail=count=0 and FSM=IDLE. Outputs: push_ready=1, slice_req_ready=1, slice_out_valid=0, slice_out_last=0, slice_out_data=0, slice_err=0, slice_first=0, q_size=0. Memory contents are not reset.
- Reset mid-stream aborts the slice immediately; no beat completes.
- Push: accepted when push_valid && push_ready. Data is written at the tail, tail wraps modulo DEPTH, count+1. With DROP_ZERO=1 and push_data==0 the push is accepted but nothing is stored.
- Push while full: dropped, no state change. There is no same-cycle pop bypass: push_ready is based on registered count only.
- Pop: effective when pop_en && count>0 && FSM==IDLE. Head wraps, count-1. Pop when empty: ignored. Pop during STREAM: ignored, so indices stay stable.
- Simultaneous effective push and pop: count unchanged; both pointers advance.
- q_size = registered count; it updates the cycle after the push/pop edge.
- Slice FSM has two states, IDLE and STREAM.
- IDLE: a request is accepted on slice_req_valid && slice_req_ready. It is valid iff start>=0, end>=0, start<=end and end<q_size, using the q_size value in the acceptance cycle.
- Invalid request: slice_err=1 for exactly the next cycle, slice_first<=0, FSM stays IDLE.
- Valid request: rd_idx<=start, rd_end<=end, slice_first<=mem[(head+start) mod DEPTH], FSM->STREAM.
- STREAM timing: slice_out_valid is asserted from the cycle after acceptance, giving 1-cycle latency.
- STREAM data: slice_out_data = mem[(head+rd_idx) mod DEPTH]. slice_out_last = (rd_idx==rd_end).
- STREAM handshake: a beat transfers on valid && ready, then rd_idx+1. Data and last must hold stable while ready is low.
- End of slice: after the last beat transfers, FSM->IDLE and slice_req_ready is high the next cycle.
- Pushes during STREAM are allowed. They write only slots beyond count, so streamed data is unaffected.
- Index arithmetic: the head+index sum uses $clog2(DEPTH) bits and wraps naturally. Validated indices always fit.

Decomposition:
- Package range_slice_pkg holds the slice_state_e enum (IDLE, STREAM) and a range_ok(start, end, size) function.
- Sub-module range_queue_store holds the storage array, head/tail/count and push/pop logic, and exposes an indexed read port.
- The top level holds the slice FSM and the output registers.

Test Plan:
- Reset, then push 10,20,30,40,50 -> q_size=5 one cycle after the last push, push_ready=1, slice_out_valid=0.
- With slice_out_ready=1, request start=1,end=3 -> beats 20,30,40 on consecutive cycles, first beat 1 cycle after acceptance, last=1 only on 40, slice_first=20.
- Same request with ready low for 3 cycles after the first beat -> 30 and slice_out_valid held stable; stream completes when ready returns.
- Invalid requests each give a one-cycle slice_err, slice_first=0 and no beats: start=3,end=1; start=0,end=5 with q_size=5; start=-1,end=2.
- DEPTH=4: push 1,2,3,4 -> push_ready=0. A fifth push is dropped. Push+pop at full -> pop only, q_size=3, head value now 2.
- pop_en during STREAM -> ignored, q_size unchanged. rst_n low mid-stream -> slice_out_valid=0 and q_size=0 without waiting for a clock edge. With DROP_ZERO=1, pushing 0 -> q_size unchanged.
